// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out stream bundle for conv_window_gen.
// master = window generator side, slave = pixel source and window consumer.
interface conv_window_gen_if #(
  parameter int DATA_SIZE = 8
);
  logic [DATA_SIZE-1:0]   din;
  logic                   din_valid;
  logic                   din_ready;
  logic [9*DATA_SIZE-1:0] win_data;
  logic                   win_valid;
  logic                   win_ready;
  logic                   win_last;
  logic                   frame_done;

  modport master (
    input  din, din_valid, win_ready,
    output din_ready, win_data, win_valid, win_last, frame_done
  );

  modport slave (
    output din, din_valid, win_ready,
    input  din_ready, win_data, win_valid, win_last, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: latency 1 (2 with WIN_OUT_REG_EN), backpressure
// stalls pixel intake while a window is held; WIN_OUT_REG_EN adds an output register stage.
module conv_window_gen #(
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32
) (
  input  logic               clk,
  input  logic               rst,
  conv_window_gen_if.master  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [DATA_SIZE-1:0]   lb0 [IMG_W];
  logic [DATA_SIZE-1:0]   lb1 [IMG_W];
  logic [DATA_SIZE-1:0]   win [3][3];
  logic [9*DATA_SIZE-1:0] win_packed;
  logic                   accept;
  logic                   emit;
  logic                   col_end;
  logic                   row_end;
  logic                   is_last;

  assign accept  = bus.din_valid && bus.din_ready;
  assign col_end = (col == CW'(IMG_W - 1));
  assign row_end = (row == RW'(IMG_H - 1));
  assign is_last = col_end && row_end;
  assign emit    = (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers carry no reset; rows 0/1 of every frame overwrite them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[col];
      win[1][2] <= lb0[col];
      win[2][2] <= bus.din;
    end
  end

  // Row-major packing: (0,0) lands in the MSBs, (2,2) in the LSBs.
  always_comb begin
    win_packed = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_packed[DATA_SIZE*(9-(3*r+c))-1 -: DATA_SIZE] = win[r][c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.frame_done <= 1'b0;
    else     bus.frame_done <= accept && is_last;
  end

`ifndef WIN_OUT_REG_EN

  // The shift window itself is the output; it only moves on accept, which
  // cannot happen while a window is stalled.
  assign bus.din_ready = !bus.win_valid || bus.win_ready;
  assign bus.win_data  = win_packed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
    end else if (accept) begin
      bus.win_valid <= emit;
      bus.win_last  <= emit && is_last;
    end else if (bus.win_ready) begin
      bus.win_valid <= 1'b0;
    end
  end

`else

  logic                   stage1_valid;
  logic                   stage1_last;
  logic                   load_out;
  logic [9*DATA_SIZE-1:0] out_data;

  // Stage 1 is the shift window; refuse pixels only when it and the output are both full and stalled.
  assign load_out      = !bus.win_valid || bus.win_ready;
  assign bus.din_ready = bus.win_ready || !(bus.win_valid && stage1_valid);
  assign bus.win_data  = out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_valid <= 1'b0;
      stage1_last  <= 1'b0;
    end else if (accept) begin
      stage1_valid <= emit;
      stage1_last  <= emit && is_last;
    end else if (load_out) begin
      stage1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
      out_data      <= '0;
    end else if (load_out) begin
      bus.win_valid <= stage1_valid;
      bus.win_last  <= stage1_last;
      out_data      <= win_packed;
    end
  end

`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image; covers both builds (WIN_OUT_REG_EN).
module tb_conv_window_gen;

`ifdef WIN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_window_gen_if #(.DATA_SIZE(8)) bus();

  conv_window_gen #(.DATA_SIZE(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [71:0] win_q[$];
  bit          last_q[$];
  int          win_cyc_q[$];
  logic [7:0]  acc_q[$];
  int          acc_cyc_q[$];
  int          fd_cnt = 0;

  int checks = 0;
  int errors = 0;

  // Observe at the falling edge: what is seen here is what the next rising edge commits.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.win_valid && bus.win_ready) begin
        win_q.push_back(bus.win_data);
        last_q.push_back(bus.win_last);
        win_cyc_q.push_back(cyc);
      end
      if (bus.din_valid && bus.din_ready) begin
        acc_q.push_back(bus.din);
        acc_cyc_q.push_back(cyc);
      end
      if (bus.frame_done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] win_at(input int i);
    return (i < win_q.size()) ? win_q[i] : 72'hx;
  endfunction

  function automatic logic [7:0] acc_at(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 8'hx;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted p.
  task automatic push(input logic [7:0] p);
    int n;
    n = 0;
    bus.din       = p;
    bus.din_valid = 1'b1;
    @(negedge clk);
    while (!bus.din_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: pixel %h not accepted, din_ready %b required 1", p, bus.din_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 16; i++) push(base + 8'(i));
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_wins(input int target, input string tag);
    int n;
    n = 0;
    while (win_q.size() < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(tag, 72'(win_q.size()), 72'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win_valid"},  72'(bus.win_valid),  72'd0);
    check({tag, "_win_last"},   72'(bus.win_last),   72'd0);
    check({tag, "_frame_done"}, 72'(bus.frame_done), 72'd0);
    check({tag, "_win_data"},   bus.win_data,        72'd0);
    check({tag, "_din_ready"},  72'(bus.din_ready),  72'd1);
  endtask

  logic [71:0] exp_w [4];
  logic [71:0] ofs;
  logic [71:0] w;
  int wb, ab, fb, n, lasts;

  initial begin
    exp_w[0] = 72'h00_01_02_04_05_06_08_09_0A;
    exp_w[1] = 72'h01_02_03_05_06_07_09_0A_0B;
    exp_w[2] = 72'h04_05_06_08_09_0A_0C_0D_0E;
    exp_w[3] = 72'h05_06_07_09_0A_0B_0D_0E_0F;
    ofs      = 72'h10_10_10_10_10_10_10_10_10;

    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.win_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame, pixels 0..15, consumer always ready
    wb = win_q.size(); ab = acc_q.size(); fb = fd_cnt;
    send_frame(8'h00);
    wait_wins(wb + 4, "t1_count");
    for (int i = 0; i < 4; i++) check($sformatf("t1_win%0d", i), win_at(wb + i), exp_w[i]);
    check("t1_last_on_final", 72'(last_q[wb + 3]), 72'd1);
    check("t1_last_on_first", 72'(last_q[wb]), 72'd0);
    check("t1_frame_done_pulses", 72'(fd_cnt - fb), 72'd1);
    check("t1_latency", 72'(win_cyc_q[wb] - acc_cyc_q[ab + 10]), 72'(LAT));

    // Consumer stalls for 5 cycles once the first window appears
    wb = win_q.size(); ab = acc_q.size();
    for (int i = 0; i <= 10; i++) push(8'(i));
    bus.win_ready = 1'b0;
    bus.din_valid = 1'b0;
    n = 0;
    while (!bus.win_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_first_window_seen", 72'(bus.win_valid), 72'd1);
    @(posedge clk);
    #1;
    bus.din       = 8'd11;
    bus.din_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t2_hold_data_c%0d", k), bus.win_data, exp_w[0]);
      check($sformatf("t2_hold_valid_c%0d", k), 72'(bus.win_valid), 72'd1);
`ifdef WIN_OUT_REG_EN
      check($sformatf("t2_din_ready_c%0d", k), 72'(bus.din_ready), 72'(k == 0));
`else
      check($sformatf("t2_din_ready_c%0d", k), 72'(bus.din_ready), 72'd0);
`endif
      @(posedge clk);
      #1;
    end
    bus.win_ready = 1'b1;
    if (acc_q.size() == ab + 11) push(8'd11);
    for (int i = 12; i < 16; i++) push(8'(i));
    bus.din_valid = 1'b0;
    wait_wins(wb + 4, "t2_count");
    for (int i = 0; i < 4; i++) check($sformatf("t2_win%0d", i), win_at(wb + i), exp_w[i]);
    check("t2_accepted", 72'(acc_q.size() - ab), 72'd16);
    for (int i = 0; i < 16; i++) check($sformatf("t2_pixel%0d", i), 72'(acc_at(ab + i)), 72'(i));

    // Sign-magnitude values pass through untouched
    wb = win_q.size();
    for (int i = 0; i < 16; i++) push((i == 0) ? 8'h85 : (i == 10) ? 8'h7F : 8'(i));
    bus.din_valid = 1'b0;
    wait_wins(wb + 4, "t3_count");
    w = win_at(wb);
    check("t3_msb_byte", 72'(w[71:64]), 72'h85);
    check("t3_lsb_byte", 72'(w[7:0]), 72'h7F);
    check("t3_win0", w, 72'h85_01_02_04_05_06_08_09_7F);

    // Two frames back to back, pixels 0..31
    wb = win_q.size(); fb = fd_cnt;
    for (int i = 0; i < 32; i++) push(8'(i));
    bus.din_valid = 1'b0;
    wait_wins(wb + 8, "t4_count");
    check("t4_f1_win0", win_at(wb), exp_w[0]);
    check("t4_f2_win0", win_at(wb + 4), 72'h10_11_12_14_15_16_18_19_1A);
    check("t4_f2_win3", win_at(wb + 7), exp_w[3] + ofs);
    lasts = 0;
    for (int i = 0; i < 8; i++) lasts += int'(last_q[wb + i]);
    check("t4_last_pulses", 72'(lasts), 72'd2);
    check("t4_last_f1", 72'(last_q[wb + 3]), 72'd1);
    check("t4_last_f2", 72'(last_q[wb + 7]), 72'd1);
    check("t4_frame_done_pulses", 72'(fd_cnt - fb), 72'd2);

    // Reset after pixel 6, then a clean frame
    for (int i = 0; i <= 6; i++) push(8'(i));
    bus.din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb = win_q.size(); fb = fd_cnt;
    send_frame(8'h00);
    wait_wins(wb + 4, "t5_count");
    for (int i = 0; i < 4; i++) check($sformatf("t5_win%0d", i), win_at(wb + i), exp_w[i]);
    check("t5_last", 72'(last_q[wb + 3]), 72'd1);
    check("t5_frame_done_pulses", 72'(fd_cnt - fb), 72'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
